// File: rtl/processor_debug_controller_pkg.sv
// Shared op codes, controller states and limits for processor_debug_controller.
package processor_debug_pkg;

    typedef enum logic [1:0] {
        OP_STATUS      = 2'd0,
        OP_CONTINUE    = 2'd1,
        OP_READ_REG    = 2'd2,
        OP_READ_CYCLES = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE,
        CONT_PULSE,
        WAIT_RUN,
        REG_SETUP,
        REG_CAPTURE,
        RESP
    } dbg_state_e;

    localparam logic [3:0]  DEBUG_REG_IP   = 4'd8;
    localparam int unsigned WAIT_RUN_GUARD = 4;

    // Register indices above the instruction pointer do not exist on the core.
    function automatic logic reg_is_readable(input logic [3:0] idx);
        return idx <= DEBUG_REG_IP;
    endfunction

endpackage

// File: rtl/processor_debug_controller_if.sv
// Host command/response channel of the debug controller.
interface processor_debug_controller_if #(
    parameter int unsigned WORD_SIZE = 18
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [3:0]           cmd_reg;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_error;
    logic [WORD_SIZE-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_reg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_error, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_error, rsp_data
    );
endinterface

// File: rtl/processor_debug_controller_run_counter.sv
// Free-running count of cycles the processor spends executing (not halted).
module debug_run_counter #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/processor_debug_controller.sv
// Host-facing debug controller: status, continue, register read, run-cycle read.
// Optional run counter enabled by defining DEBUG_CTRL_CYCLE_COUNT_EN.
module processor_debug_controller
    import processor_debug_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    processor_debug_controller_if.slave host,
    input  logic                  wait_for_continue,
    output logic                  wait_continue_execution,
    output logic                  debug_get_param,
    output logic [3:0]            debug_reg_addr,
    input  logic [WORD_SIZE-1:0]  debug_data_in,
    output logic                  halted
);
    localparam logic [1:0] WAIT_LAST = 2'(WAIT_RUN_GUARD - 1);

    dbg_state_e           state_q, state_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic [3:0]           addr_q, addr_d;
    logic [1:0]           wait_cnt_q, wait_cnt_d;
    logic                 halted_q;

`ifdef DEBUG_CTRL_CYCLE_COUNT_EN
    logic [WORD_SIZE-1:0] run_count;

    debug_run_counter #(.WIDTH(WORD_SIZE)) u_run_counter (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .en_i    (!wait_for_continue),
        .count_o (run_count)
    );
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= wait_for_continue;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    // Every rejected or immediate command answers on the next cycle.
                    state_d = RESP;
                    data_d  = '0;
                    err_d   = 1'b0;
                    case (cmd_op_e'(host.cmd_op))
                        OP_STATUS: data_d = WORD_SIZE'(halted_q);
                        OP_CONTINUE: begin
                            if (halted_q) state_d = CONT_PULSE;
                            else          err_d   = 1'b1;
                        end
                        OP_READ_REG: begin
                            if (halted_q && reg_is_readable(host.cmd_reg)) begin
                                state_d = REG_SETUP;
                                addr_d  = host.cmd_reg;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_READ_CYCLES: begin
`ifdef DEBUG_CTRL_CYCLE_COUNT_EN
                            data_d = run_count;
`else
                            err_d  = 1'b1;
`endif
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            CONT_PULSE: begin
                state_d    = WAIT_RUN;
                wait_cnt_d = '0;
            end
            WAIT_RUN: begin
                // A resume seen on the last guard cycle still counts as success.
                if (!wait_for_continue) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            REG_SETUP: state_d = REG_CAPTURE;
            REG_CAPTURE: begin
                state_d = RESP;
                data_d  = debug_data_in;
                err_d   = 1'b0;
            end
            RESP: begin
                if (host.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host.cmd_ready          = (state_q == IDLE) && reset_n;
        host.rsp_valid          = (state_q == RESP);
        host.rsp_data           = (state_q == RESP) ? data_q : '0;
        host.rsp_error          = (state_q == RESP) && err_q;
        wait_continue_execution = (state_q == CONT_PULSE);
        debug_get_param         = (state_q == REG_SETUP) || (state_q == REG_CAPTURE);
        debug_reg_addr          = debug_get_param ? addr_q : '0;
        halted                  = halted_q;
    end

endmodule
